// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush/bubble sequencing for load-use, mult/div occupancy and taken branches.
// Optional HAZARD_PERF_EN adds saturating stall_cycles and flush_count counters.
module hazard_stall_controller #(
    parameter int unsigned MULDIV_LAT = 32,
    parameter int unsigned REG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_muldiv,
    input  logic             id_reads_hilo,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             muldiv_start,
    output logic             muldiv_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [15:0]      flush_count
`endif
);

    localparam int unsigned CNT_W = $clog2(MULDIV_LAT + 1);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_use;
    logic             hilo_hz;
    logic             busy_int;

    always_comb begin
        busy_int = (state == BUSY);
        load_use = ex_mem_read && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        hilo_hz  = busy_int && (id_muldiv || id_reads_hilo);
    end

    // Mealy outputs: reset overrides everything, then branch, then stall, then normal flow.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        muldiv_start = 1'b0;
        muldiv_busy  = 1'b0;
        if (rst_n) begin
            muldiv_busy = busy_int;
            if (ex_branch_taken) begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use || hilo_hz) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_id_flush  = 1'b0;
                id_ex_bubble = 1'b1;
            end else begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b0;
                id_ex_bubble = 1'b0;
                muldiv_start = id_muldiv && (state == RUN);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == RUN) begin
            if (muldiv_start) begin
                state_nxt = BUSY;
                cnt_nxt   = CNT_W'(MULDIV_LAT);
            end
        end else begin
            if (cnt == CNT_W'(1)) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (ex_branch_taken && (flush_count != '1))
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: directed scenarios plus random stimulus against a cycle-indexed occupancy model.
module tb_hazard_stall_controller;

    localparam int unsigned LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_muldiv, id_reads_hilo, ex_mem_read, ex_branch_taken;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, muldiv_start, muldiv_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int checks = 0;
    int errors = 0;
    // Occupancy as an absolute cycle window: busy while cyc <= busy_end.
    int cyc = 0;
    int busy_end = -1;
    logic exp_start;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MULDIV_LAT(LAT), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_muldiv(id_muldiv), .id_reads_hilo(id_reads_hilo),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic busy, lu, hz;
        logic e_pc, e_ifw, e_fl, e_bub, e_busy;
        busy = rst_n && (cyc <= busy_end);
        lu = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        hz = busy && (id_muldiv || id_reads_hilo);
        e_busy = busy;
        exp_start = 1'b0;
        if (!rst_n) begin
            e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
        end else if (ex_branch_taken) begin
            e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1;
        end else if (lu || hz) begin
            e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1;
        end else begin
            e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
            exp_start = id_muldiv && !busy;
        end
        chk("pc_write", pc_write, e_pc);
        chk("if_id_write", if_id_write, e_ifw);
        chk("if_id_flush", if_id_flush, e_fl);
        chk("id_ex_bubble", id_ex_bubble, e_bub);
        chk("muldiv_start", muldiv_start, exp_start);
        chk("muldiv_busy", muldiv_busy, e_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (exp_start) busy_end = cyc + int'(LAT);
            cyc++;
        end
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic md, input logic hl, input logic mr,
                         input logic [4:0] xrt, input logic br);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; id_muldiv = md; id_reads_hilo = hl;
        ex_mem_read = mr; ex_rt = xrt; ex_branch_taken = br;
    endtask

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic md, input logic hl, input logic mr,
                        input logic [4:0] xrt, input logic br);
        drive(rs, rt, urt, md, hl, mr, xrt, br);
        #1;
        check_outputs();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_outputs();
        tick();
        tick();
        #3 rst_n = 1'b1;
        // Load-use on rs: single stall cycle, then the load has moved on
        step(8, 1, 0, 0, 0, 1, 8, 0);
        step(8, 1, 0, 0, 0, 0, 8, 0);
        // Load to $0 never stalls
        step(0, 0, 1, 0, 0, 1, 0, 0);
        // rt gating
        step(1, 9, 0, 0, 0, 1, 9, 0);
        step(1, 9, 1, 0, 0, 1, 9, 0);
        step(1, 9, 1, 0, 0, 0, 0, 0);
        // div issue, mflo stalls during occupancy, proceeds right after
        step(2, 3, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < int'(LAT) + 1; i++) step(2, 3, 0, 0, 1, 0, 0, 0);
        // Branch cancels a same-cycle issue
        step(2, 3, 1, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Branch during occupancy with mfhi stalled: flush wins, countdown continues
        step(2, 3, 1, 1, 0, 0, 0, 0);
        step(2, 3, 0, 0, 1, 0, 0, 0);
        step(2, 3, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < int'(LAT); i++) step(2, 3, 0, 0, 1, 0, 0, 0);
        // Async reset mid-countdown, between edges
        step(2, 3, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 1, 0, 0);
        #2 rst_n = 1'b0;
        busy_end = -1;
        #1;
        check_outputs();
        tick();
        #3 rst_n = 1'b1;
        step(2, 3, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Randomized traffic over a small register set so hazards collide often
        for (int n = 0; n < 400; n++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 60) == 0) begin
                #2 rst_n = 1'b0;
                busy_end = -1;
                #1;
                check_outputs();
                tick();
                #3 rst_n = 1'b1;
            end else begin
                #1;
                check_outputs();
                tick();
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
